cfg_mgmt_arbiter: RTL

//  Shares the PCIe core cfg_mgmt DW read/write port among NUM_REQ requesters (e.g. RP enumeration

---
 rtl/cfg_mgmt_arb_pkg.sv | 25 ++
 rtl/cfg_mgmt_arbiter_rr_arbiter.sv | 33 +++
 rtl/cfg_mgmt_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cfg_mgmt_arb_pkg.sv
// Shared widths, state encoding and request payload for the cfg_mgmt port arbiter.
package cfg_mgmt_arb_pkg;

    localparam int unsigned CFG_ADDR_W = 10;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_BE_W   = 4;

    localparam logic [CFG_DATA_W-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  write;
        logic                  type1;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] wdata;
        logic [CFG_BE_W-1:0]   be;
    } cfg_req_t;

endpackage

// File: rtl/cfg_mgmt_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan offsets 1..NUM_REQ so the last winner has the lowest priority.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_cand = IDX_W'((32'(i_ptr) + off) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found            = 1'b1;
                o_grant_c[w_cand]  = 1'b1;
                o_idx_c            = w_cand;
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/cfg_mgmt_arbiter.sv
// Shares the PCIe core cfg_mgmt DW port among NUM_REQ requesters, one access at a
// time, with round-robin selection and a per-access completion timeout.
module cfg_mgmt_arbiter
    import cfg_mgmt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          user_clk,
    input  logic                          user_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*CFG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*CFG_DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*CFG_BE_W-1:0]   req_be,
    input  logic [NUM_REQ-1:0]            req_type1,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [CFG_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [CFG_ADDR_W-1:0]         cfg_mgmt_addr,
    output logic                          cfg_mgmt_write,
    output logic [CFG_DATA_W-1:0]         cfg_mgmt_write_data,
    output logic [CFG_BE_W-1:0]           cfg_mgmt_byte_enable,
    output logic                          cfg_mgmt_read,
    output logic                          cfg_mgmt_type1_cfg_reg_access,
    input  logic [CFG_DATA_W-1:0]         cfg_mgmt_read_data,
    input  logic                          cfg_mgmt_read_write_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [IDX_W-1:0]     r_ptr;
    logic [TMR_W-1:0]     r_timer;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_any;
    logic [NUM_REQ-1:0]   w_ptr_oh;
    cfg_req_t             w_sel;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_tmo;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_win_oh),
        .o_idx_c   (w_win_idx),
        .o_any_c   (w_win_any)
    );

    // Payload of the winning requester.
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_sel.write = req_write[i];
                w_sel.type1 = req_type1[i];
                w_sel.addr  = req_addr[i*CFG_ADDR_W +: CFG_ADDR_W];
                w_sel.wdata = req_wdata[i*CFG_DATA_W +: CFG_DATA_W];
                w_sel.be    = req_be[i*CFG_BE_W +: CFG_BE_W];
            end
        end
    end

    assign w_ptr_oh = NUM_REQ'(1) << r_ptr;

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_win_any) w_state_nxt = BUSY;
            BUSY:    if (cfg_mgmt_read_write_done || (r_timer == TMR_LAST)) w_state_nxt = RESP;
            RESP:    w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Done beats timeout when both land on the last BUSY cycle.
    always_comb begin
        w_accept  = 1'b0;
        w_done    = 1'b0;
        w_tmo     = 1'b0;
        req_ready = '0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_accept  = w_win_any && !user_reset;
                req_ready = user_reset ? '0 : w_win_oh;
            end
            BUSY: begin
                w_done = cfg_mgmt_read_write_done;
                w_tmo  = !cfg_mgmt_read_write_done && (r_timer == TMR_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_timer <= '0;
        end else if (w_accept) begin
            r_ptr   <= w_win_idx;
            r_timer <= '0;
        end else if (r_state == BUSY) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Core-facing registers double as the latched request fields.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            cfg_mgmt_addr                 <= '0;
            cfg_mgmt_write                <= 1'b0;
            cfg_mgmt_read                 <= 1'b0;
            cfg_mgmt_write_data           <= '0;
            cfg_mgmt_byte_enable          <= '0;
            cfg_mgmt_type1_cfg_reg_access <= 1'b0;
        end else if (w_accept) begin
            cfg_mgmt_addr                 <= w_sel.addr;
            cfg_mgmt_write                <= w_sel.write;
            cfg_mgmt_read                 <= !w_sel.write;
            cfg_mgmt_write_data           <= w_sel.wdata;
            cfg_mgmt_byte_enable          <= w_sel.be;
            cfg_mgmt_type1_cfg_reg_access <= w_sel.type1;
        end else if (w_done || w_tmo) begin
            cfg_mgmt_addr                 <= '0;
            cfg_mgmt_write                <= 1'b0;
            cfg_mgmt_read                 <= 1'b0;
            cfg_mgmt_write_data           <= '0;
            cfg_mgmt_byte_enable          <= '0;
            cfg_mgmt_type1_cfg_reg_access <= 1'b0;
        end
    end

    // Response pulses during RESP; data and timeout flag hold until the next one.
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (w_done) begin
                rsp_valid   <= w_ptr_oh;
                rsp_rdata   <= cfg_mgmt_write ? '0 : cfg_mgmt_read_data;
                rsp_timeout <= 1'b0;
            end else if (w_tmo) begin
                rsp_valid   <= w_ptr_oh;
                rsp_rdata   <= TIMEOUT_RDATA;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule
